// File: rtl/raifes_qspi_arbiter_pkg.sv
// Shared constants for the QSPI arbiter slice: HASTI bus widths and codes,
// the engine address width, arbiter FSM states and the grant selector.
package raifes_qspi_arbiter_pkg;

  localparam int unsigned HASTI_ADDR_WIDTH  = 32;
  localparam int unsigned HASTI_BUS_WIDTH   = 32;
  localparam int unsigned HASTI_SIZE_WIDTH  = 3;
  localparam int unsigned HASTI_TRANS_WIDTH = 2;
  localparam int unsigned HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  localparam int unsigned QSPI_ENG_ADDR_W = 24;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ISSUE = 3'd1,
    ARB_BUSY  = 3'd2,
    ARB_ERR   = 3'd3,
    ARB_RESP  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/raifes_qspi_ahb_port.sv
// One HASTI slave port of the QSPI arbiter.
// Captures the address phase, holds the pending flag, registers hwdata in
// the first data-phase cycle and generates hready/hresp/hrdata.
// Ports: haddr/hsize/htrans/hwrite/hwdata from the master; hrdata/hready/
// hresp back to it; grant/resp/err_phase/err_flag/rdata_load/rdata from the
// arbiter FSM; pending and cap_* (captured request) to the arbiter.
module raifes_qspi_ahb_port
  import raifes_qspi_arbiter_pkg::*;
(
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic                         hwrite,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp,
  input  logic                         grant,
  input  logic                         resp,
  input  logic                         err_phase,
  input  logic                         err_flag,
  input  logic                         rdata_load,
  input  logic [HASTI_BUS_WIDTH-1:0]   rdata,
  output logic                         pending,
  output logic [QSPI_ENG_ADDR_W-1:0]   cap_addr,
  output logic [HASTI_SIZE_WIDTH-1:0]  cap_size,
  output logic                         cap_write,
  output logic [HASTI_BUS_WIDTH-1:0]   cap_wdata
);

  logic                        pending_q, pending_d;
  logic                        data_phase_q, data_phase_d;
  logic [QSPI_ENG_ADDR_W-1:0]  addr_q, addr_d;
  logic [HASTI_SIZE_WIDTH-1:0] size_q, size_d;
  logic                        write_q, write_d;
  logic [HASTI_BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [HASTI_BUS_WIDTH-1:0]  hrdata_q, hrdata_d;
  logic                        capture;
  logic                        done_here;
  logic                        unused_addr_hi;

  // Only the device byte address reaches the engine; htrans[0] only splits SEQ/NONSEQ.
  assign unused_addr_hi = ^{haddr[HASTI_ADDR_WIDTH-1:QSPI_ENG_ADDR_W], htrans[0]};

  assign done_here = grant & resp;
  // Completing cycle raises hready so a new address phase is taken at the same edge.
  assign hready    = ~pending_q | done_here;
  assign hresp     = HASTI_RESP_WIDTH'((grant & err_phase) | (done_here & err_flag));
  assign capture   = htrans[1] & hready;

  assign hrdata    = hrdata_q;
  assign pending   = pending_q;
  assign cap_addr  = addr_q;
  assign cap_size  = size_q;
  assign cap_write = write_q;
  // A grant taken in the first data-phase cycle sees hwdata before it is registered.
  assign cap_wdata = data_phase_q ? hwdata : wdata_q;

  always_comb begin
    pending_d    = pending_q;
    data_phase_d = capture;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    hrdata_d     = hrdata_q;
    if (data_phase_q) wdata_d = hwdata;
    if (capture) begin
      pending_d = 1'b1;
      addr_d    = haddr[QSPI_ENG_ADDR_W-1:0];
      size_d    = hsize;
      write_d   = hwrite;
    end else if (done_here) begin
      pending_d = 1'b0;
    end
    if (grant & rdata_load) hrdata_d = rdata;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      pending_q    <= 1'b0;
      data_phase_q <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      hrdata_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      data_phase_q <= data_phase_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      hrdata_q     <= hrdata_d;
    end
  end

endmodule

// File: rtl/raifes_qspi_arbiter.sv
// Shares one QSPI transaction engine between the imem and dmem HASTI ports.
// Ports: iClk/iReset (sync, active-high); imem_* and dmem_* HASTI slave
// ports; oEng_* request to the engine and iEng_* ack/done/data/error back.
// dmem wins contention unless imem has waited STARVE_MAX dmem grants.
// CNT_W must satisfy 2**CNT_W > STARVE_MAX.
module raifes_qspi_arbiter
  import raifes_qspi_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  imem_haddr,
  input  logic [HASTI_SIZE_WIDTH-1:0]  imem_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] imem_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   imem_hrdata,
  output logic                         imem_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  imem_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  dmem_haddr,
  input  logic [HASTI_SIZE_WIDTH-1:0]  dmem_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] dmem_htrans,
  input  logic                         dmem_hwrite,
  input  logic [HASTI_BUS_WIDTH-1:0]   dmem_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   dmem_hrdata,
  output logic                         dmem_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  dmem_hresp,
  output logic                         oEng_Req,
  output logic                         oEng_Write,
  output logic [QSPI_ENG_ADDR_W-1:0]   oEng_Addr,
  output logic [HASTI_SIZE_WIDTH-1:0]  oEng_Size,
  output logic [HASTI_BUS_WIDTH-1:0]   oEng_WData,
  input  logic                         iEng_Ack,
  input  logic                         iEng_Done,
  input  logic [HASTI_BUS_WIDTH-1:0]   iEng_RData,
  input  logic                         iEng_Err
);

  arb_state_e                  state_q, state_d;
  arb_gnt_e                    gnt_q, gnt_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        eng_write_q, eng_write_d;
  logic [QSPI_ENG_ADDR_W-1:0]  eng_addr_q, eng_addr_d;
  logic [HASTI_SIZE_WIDTH-1:0] eng_size_q, eng_size_d;
  logic [HASTI_BUS_WIDTH-1:0]  eng_wdata_q, eng_wdata_d;
  logic                        rdata_load;
  logic                        pick_imem;

  logic                        i_pend, d_pend;
  logic [QSPI_ENG_ADDR_W-1:0]  i_addr, d_addr;
  logic [HASTI_SIZE_WIDTH-1:0] i_size, d_size;
  logic                        i_write, d_write;
  logic [HASTI_BUS_WIDTH-1:0]  i_wdata, d_wdata;
  logic                        st_resp, st_err;

  assign st_resp   = (state_q == ARB_RESP);
  assign st_err    = (state_q == ARB_ERR);
  assign pick_imem = i_pend & (~d_pend | (cnt_q >= CNT_W'(STARVE_MAX)));

  raifes_qspi_ahb_port u_imem_port (
    .iClk(iClk), .iReset(iReset),
    .haddr(imem_haddr), .hsize(imem_hsize), .htrans(imem_htrans),
    .hwrite(1'b0), .hwdata('0),
    .hrdata(imem_hrdata), .hready(imem_hready), .hresp(imem_hresp),
    .grant(gnt_q == GNT_IMEM), .resp(st_resp), .err_phase(st_err),
    .err_flag(err_q), .rdata_load(rdata_load), .rdata(iEng_RData),
    .pending(i_pend), .cap_addr(i_addr), .cap_size(i_size),
    .cap_write(i_write), .cap_wdata(i_wdata)
  );

  raifes_qspi_ahb_port u_dmem_port (
    .iClk(iClk), .iReset(iReset),
    .haddr(dmem_haddr), .hsize(dmem_hsize), .htrans(dmem_htrans),
    .hwrite(dmem_hwrite), .hwdata(dmem_hwdata),
    .hrdata(dmem_hrdata), .hready(dmem_hready), .hresp(dmem_hresp),
    .grant(gnt_q == GNT_DMEM), .resp(st_resp), .err_phase(st_err),
    .err_flag(err_q), .rdata_load(rdata_load), .rdata(iEng_RData),
    .pending(d_pend), .cap_addr(d_addr), .cap_size(d_size),
    .cap_write(d_write), .cap_wdata(d_wdata)
  );

  assign oEng_Req   = (state_q == ARB_ISSUE);
  assign oEng_Write = eng_write_q;
  assign oEng_Addr  = eng_addr_q;
  assign oEng_Size  = eng_size_q;
  assign oEng_WData = eng_wdata_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    eng_write_d = eng_write_q;
    eng_addr_d  = eng_addr_q;
    eng_size_d  = eng_size_q;
    eng_wdata_d = eng_wdata_q;
    rdata_load  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_pend | d_pend) begin
          err_d   = 1'b0;
          state_d = ARB_ISSUE;
          if (pick_imem) begin
            gnt_d       = GNT_IMEM;
            cnt_d       = '0;
            eng_write_d = i_write;
            eng_addr_d  = i_addr;
            eng_size_d  = i_size;
            eng_wdata_d = i_wdata;
          end else begin
            gnt_d       = GNT_DMEM;
            if (i_pend && (cnt_q < CNT_W'(STARVE_MAX))) cnt_d = cnt_q + 1'b1;
            eng_write_d = d_write;
            eng_addr_d  = d_addr;
            eng_size_d  = d_size;
            eng_wdata_d = d_wdata;
          end
        end
      end
      ARB_ISSUE: begin
        if (iEng_Ack) begin
          // Done alongside ack counts as ack then done.
          if (iEng_Done) begin
            rdata_load = 1'b1;
            err_d      = iEng_Err;
            state_d    = iEng_Err ? ARB_ERR : ARB_RESP;
          end else begin
            state_d = ARB_BUSY;
          end
        end
      end
      ARB_BUSY: begin
        if (iEng_Done) begin
          rdata_load = 1'b1;
          err_d      = iEng_Err;
          state_d    = iEng_Err ? ARB_ERR : ARB_RESP;
        end
      end
      ARB_ERR:  state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= GNT_IMEM;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      eng_write_q <= 1'b0;
      eng_addr_q  <= '0;
      eng_size_q  <= '0;
      eng_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      eng_write_q <= eng_write_d;
      eng_addr_q  <= eng_addr_d;
      eng_size_q  <= eng_size_d;
      eng_wdata_q <= eng_wdata_d;
    end
  end

endmodule

// File: tb/tb_raifes_qspi_arbiter.sv
// Self-checking bench for raifes_qspi_arbiter: two master processes, an
// engine responder and scoreboards for engine requests and port responses.
`timescale 1ns/1ps
module tb_raifes_qspi_arbiter;
  import raifes_qspi_arbiter_pkg::*;

  logic        iClk = 1'b0;
  logic        iReset;
  logic [31:0] imem_haddr, dmem_haddr;
  logic [2:0]  imem_hsize, dmem_hsize;
  logic [1:0]  imem_htrans, dmem_htrans;
  logic        dmem_hwrite;
  logic [31:0] dmem_hwdata;
  logic [31:0] imem_hrdata, dmem_hrdata;
  logic        imem_hready, dmem_hready;
  logic [0:0]  imem_hresp, dmem_hresp;
  logic        oEng_Req, oEng_Write;
  logic [23:0] oEng_Addr;
  logic [2:0]  oEng_Size;
  logic [31:0] oEng_WData;
  logic        iEng_Ack, iEng_Done, iEng_Err;
  logic [31:0] iEng_RData;

  raifes_qspi_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .iClk(iClk), .iReset(iReset),
    .imem_haddr(imem_haddr), .imem_hsize(imem_hsize), .imem_htrans(imem_htrans),
    .imem_hrdata(imem_hrdata), .imem_hready(imem_hready), .imem_hresp(imem_hresp),
    .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize), .dmem_htrans(dmem_htrans),
    .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
    .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .oEng_Req(oEng_Req), .oEng_Write(oEng_Write), .oEng_Addr(oEng_Addr),
    .oEng_Size(oEng_Size), .oEng_WData(oEng_WData),
    .iEng_Ack(iEng_Ack), .iEng_Done(iEng_Done), .iEng_RData(iEng_RData),
    .iEng_Err(iEng_Err)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; } req_t;
  typedef struct { logic write; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic write; logic [23:0] addr; logic [2:0] size; logic [31:0] wdata; } eng_t;

  req_t req_q[2][$];
  rsp_t rsp_q[2][$];
  eng_t eng_q[$];
  int   req_cyc_q[$];
  int   cmp_cyc_q[2][$];
  bit   dph[2];
  bit   pres[2];
  bit   eng_busy;
  int   cyc = 0;
  int unsigned ack_dly, done_dly;
  int   n_chk = 0, n_err = 0;

  always @(posedge iClk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] eng_rdata(input logic [23:0] a);
    return (a == 24'h000010) ? 32'hDEADBEEF : {8'hA5, a};
  endfunction

  function automatic logic eng_err(input logic [23:0] a);
    return a[23:20] == 4'hE;
  endfunction

  function automatic logic get_rdy(input int p);
    return (p == 0) ? imem_hready : dmem_hready;
  endfunction
  function automatic logic get_resp(input int p);
    return (p == 0) ? imem_hresp[0] : dmem_hresp[0];
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? imem_hrdata : dmem_hrdata;
  endfunction

  task automatic drive_addr(input int p, input logic [1:0] tr, input logic [31:0] a, input logic w);
    if (p == 0) begin
      imem_htrans = tr; imem_haddr = a;
    end else begin
      dmem_htrans = tr; dmem_haddr = a; dmem_hwrite = w;
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic w, input logic [31:0] wd);
    req_t r;
    rsp_t e;
    r.addr = a; r.write = w; r.wdata = wd;
    e.write = w; e.err = eng_err(a[23:0]); e.rdata = eng_rdata(a[23:0]);
    req_q[p].push_back(r);
    rsp_q[p].push_back(e);
  endtask

  task automatic expect_eng(input logic [31:0] a, input logic w, input logic [31:0] wd);
    eng_t e;
    e.write = w; e.addr = a[23:0]; e.size = 3'd2; e.wdata = wd;
    eng_q.push_back(e);
  endtask

  // Master + response monitor for one port.
  task automatic port_proc(input int p);
    req_t cur;
    rsp_t e;
    bit   err_seen = 0;
    bit   will_cap;
    forever begin
      @(negedge iClk);
      will_cap = 0;
      if (iReset) begin
        dph[p] = 0; pres[p] = 0; err_seen = 0;
        rsp_q[p].delete(); req_q[p].delete();
      end else begin
        if (dph[p]) begin
          if (get_rdy(p)) begin
            if (rsp_q[p].size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
              e = rsp_q[p].pop_front();
              chk((p == 0) ? "i_hresp" : "d_hresp", 64'(get_resp(p)), 64'(e.err));
              if (e.err) chk("err_first_cycle", 64'(err_seen), 1);
              if (!e.write && !e.err)
                chk((p == 0) ? "i_hrdata" : "d_hrdata", 64'(get_rdata(p)), 64'(e.rdata));
            end
            cmp_cyc_q[p].push_back(cyc);
            dph[p] = 0;
          end
          err_seen = get_resp(p);
        end else begin
          chk((p == 0) ? "i_idle" : "d_idle", {get_rdy(p), get_resp(p)}, 2'b10);
        end
        will_cap = pres[p] && get_rdy(p);
      end
      @(posedge iClk); #1;
      if (will_cap) begin
        dph[p] = 1; err_seen = 0; pres[p] = 0;
        if (p == 1) dmem_hwdata = cur.wdata;
      end
      if (!pres[p] && req_q[p].size() > 0 && !iReset) begin
        cur = req_q[p].pop_front();
        drive_addr(p, HASTI_TRANS_NONSEQ, cur.addr, cur.write);
        pres[p] = 1;
      end else if (!pres[p]) begin
        drive_addr(p, HASTI_TRANS_IDLE, cur.addr, 1'b0);
      end
    end
  endtask

  // Engine request monitor.
  initial begin : eng_mon
    bit   req_prev = 0;
    eng_t e;
    forever begin
      @(negedge iClk);
      if (iReset) req_prev = 0;
      else begin
        if (oEng_Req && !req_prev) begin
          req_cyc_q.push_back(cyc);
          if (eng_q.size() == 0) chk("eng_unexpected", 1, 0);
          else begin
            e = eng_q.pop_front();
            chk("eng_req", {oEng_Write, oEng_Addr, oEng_Size, (oEng_Write ? oEng_WData : 32'h0)},
                {e.write, e.addr, e.size, (e.write ? e.wdata : 32'h0)});
          end
        end
        req_prev = oEng_Req;
      end
    end
  end

  // Engine responder.
  initial begin : eng_rsp
    int unsigned cnt;
    logic [23:0] a;
    cnt = 0; eng_busy = 0; a = '0;
    forever begin
      @(posedge iClk); #1;
      iEng_Ack = 0; iEng_Done = 0; iEng_Err = 0; iEng_RData = 32'h0BAD0BAD;
      if (iReset) begin
        eng_busy = 0; cnt = 0;
      end else if (!eng_busy) begin
        if (oEng_Req) begin
          if (cnt == ack_dly) begin
            iEng_Ack = 1; cnt = 0; a = oEng_Addr;
            if (done_dly == 0) begin
              iEng_Done = 1; iEng_RData = eng_rdata(a); iEng_Err = eng_err(a);
            end else eng_busy = 1;
          end else cnt++;
        end
      end else if (cnt + 1 == done_dly) begin
        iEng_Done = 1; iEng_RData = eng_rdata(a); iEng_Err = eng_err(a);
        eng_busy = 0; cnt = 0;
      end else cnt++;
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((req_q[0].size() > 0 || req_q[1].size() > 0 || rsp_q[0].size() > 0 ||
            rsp_q[1].size() > 0 || eng_q.size() > 0 || dph[0] || dph[1] ||
            pres[0] || pres[1]) && n < budget) begin
      @(negedge iClk);
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
    repeat (2) @(negedge iClk);
  endtask

  task automatic clear_cyc();
    req_cyc_q.delete();
    cmp_cyc_q[0].delete();
    cmp_cyc_q[1].delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    iReset = 1;
    imem_haddr = '0; imem_hsize = 3'd2; imem_htrans = HASTI_TRANS_IDLE;
    dmem_haddr = '0; dmem_hsize = 3'd2; dmem_htrans = HASTI_TRANS_IDLE;
    dmem_hwrite = 0; dmem_hwdata = '0;
    iEng_Ack = 0; iEng_Done = 0; iEng_Err = 0; iEng_RData = '0;
    ack_dly = 2; done_dly = 5;
    fork
      port_proc(0);
      port_proc(1);
    join_none
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("rst_hready", {imem_hready, dmem_hready}, 2'b11);
    chk("rst_hresp", {imem_hresp, dmem_hresp}, 2'b00);
    chk("rst_hrdata", {imem_hrdata, dmem_hrdata}, 64'h0);
    chk("rst_eng", {oEng_Req, oEng_Write, oEng_Addr, oEng_WData}, 58'h0);
    @(posedge iClk); #1;
    iReset = 0;
    @(negedge iClk);

    // Single imem read with ack after 2 cycles and done 5 cycles later.
    clear_cyc();
    expect_eng(32'h0000_0010, 1'b0, 32'h0);
    issue(0, 32'h0000_0010, 1'b0, 32'h0);
    wait_idle("t1", 100);
    if (req_cyc_q.size() == 0 || cmp_cyc_q[0].size() == 0) chk("t1_latency_missing", 1, 0);
    else chk("t1_latency", 64'(cmp_cyc_q[0][0] - req_cyc_q[0]), 64'd8);
    chk("t1_hold", imem_hrdata, 32'hDEADBEEF);

    // dmem write.
    expect_eng(32'h0000_0100, 1'b1, 32'h12345678);
    issue(1, 32'h0000_0100, 1'b1, 32'h12345678);
    wait_idle("t2", 100);
    chk("t2_imem_hold", imem_hrdata, 32'hDEADBEEF);

    // Contention: dmem four times, then imem, then the last dmem.
    ack_dly = 0; done_dly = 0;
    for (int i = 0; i < 4; i++) expect_eng(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    expect_eng(32'h0000_0200, 1'b0, 32'h0);
    expect_eng(32'h1010, 1'b0, 32'h0);
    issue(0, 32'h0000_0200, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) issue(1, 32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    wait_idle("t3", 200);
    // Starvation counter cleared: contention again favours dmem first.
    expect_eng(32'h1100, 1'b0, 32'h0);
    expect_eng(32'h0000_0300, 1'b0, 32'h0);
    issue(0, 32'h0000_0300, 1'b0, 32'h0);
    issue(1, 32'h1100, 1'b0, 32'h0);
    wait_idle("t3b", 100);

    // Engine error on a dmem read.
    ack_dly = 1; done_dly = 3;
    expect_eng(32'h00E0_0020, 1'b0, 32'h0);
    issue(1, 32'h00E0_0020, 1'b0, 32'h0);
    wait_idle("t4", 100);
    chk("t4_imem_hold", imem_hrdata, 32'hA5000300);

    // Reset while the engine is busy.
    ack_dly = 0; done_dly = 30;
    expect_eng(32'h0000_0040, 1'b0, 32'h0);
    issue(0, 32'h0000_0040, 1'b0, 32'h0);
    n = 0;
    while (!eng_busy && n < 50) begin @(negedge iClk); n++; end
    if (n >= 50) chk("t5_busy_timeout", 1, 0);
    @(negedge iClk);
    @(posedge iClk); #1;
    iReset = 1;
    @(posedge iClk);
    @(negedge iClk);
    chk("t5_rst", {oEng_Req, imem_hready, dmem_hready}, 3'b011);
    @(posedge iClk); #1;
    iReset = 0;
    eng_q.delete();
    @(negedge iClk);
    ack_dly = 1; done_dly = 2;
    expect_eng(32'h0000_0044, 1'b0, 32'h0);
    issue(0, 32'h0000_0044, 1'b0, 32'h0);
    wait_idle("t5", 100);

    // Back-to-back imem reads, second address taken in the response cycle.
    clear_cyc();
    expect_eng(32'h0000_0080, 1'b0, 32'h0);
    expect_eng(32'h0000_0084, 1'b0, 32'h0);
    issue(0, 32'h0000_0080, 1'b0, 32'h0);
    issue(0, 32'h0000_0084, 1'b0, 32'h0);
    wait_idle("t6", 100);
    if (req_cyc_q.size() < 2 || cmp_cyc_q[0].size() < 2) chk("t6_missing", 1, 0);
    else chk("t6_b2b_gap", 64'(req_cyc_q[1] - cmp_cyc_q[0][0]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
